// File: rtl/alu_div_pkg.sv
// -----------------------------------------------------------------------------
// alu_div_pkg
//   Shared definitions for the divider control path of the clock-gated ALU.
//   Contents:
//     div_state_t          sequencer state encoding (IDLE, LAUNCH, WAIT, DONE)
//     DIV_DZ_QUOT          quotient reported on divide-by-zero (all ones)
//     DIV_INT_MIN          most negative 16-bit value (dividend of the overflow case)
//     DIV_TIMEOUT_DEFAULT  default WAIT-state cycle budget before the divider is abandoned
// -----------------------------------------------------------------------------
package alu_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } div_state_t;

   localparam logic [15:0] DIV_DZ_QUOT         = 16'hFFFF;
   localparam logic [15:0] DIV_INT_MIN         = 16'h8000;
   localparam int          DIV_TIMEOUT_DEFAULT = 24;

endpackage

// File: rtl/div_op_sequencer.sv
// -----------------------------------------------------------------------------
// div_op_sequencer
//   Control stage in front of the multi-cycle signed divider. Accepts an operand
//   pair over valid/ready, resolves divide-by-zero and INT_MIN/-1 locally without
//   waking the divider, otherwise launches the divider with a one-cycle start
//   pulse, waits (bounded) for its result, and holds the result until consumed.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      operand handshake (ready only in IDLE)
//   op_a, op_b               signed dividend / divisor
//   div_start                one-cycle launch pulse to the divider
//   div_a, div_b             latched operands presented to the divider
//   div_clk_en               divider clock-gate enable (LAUNCH through capture)
//   div_quot, div_rem        divider results, sampled when div_valid is high
//   div_valid                divider result strobe (only honoured in WAIT)
//   res_valid/res_ready      result handshake (valid only in DONE)
//   res_quot, res_rem        signed result
//   res_dz, res_ovf, res_tmo divide-by-zero, overflow and timeout flags
//   busy                     high whenever not IDLE
// -----------------------------------------------------------------------------
module div_op_sequencer
   import alu_div_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int TIMEOUT_CYC = DIV_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_clk_en,
   input  logic [WIDTH-1:0] div_quot,
   input  logic [WIDTH-1:0] div_rem,
   input  logic             div_valid,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_quot,
   output logic [WIDTH-1:0] res_rem,
   output logic             res_dz,
   output logic             res_ovf,
   output logic             res_tmo,
   output logic             busy
);

   localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   // Sign-extending the 16-bit all-ones constant keeps it all-ones at any width;
   // INT_MIN is rebuilt from its sign bit so it tracks WIDTH as well.
   localparam logic [WIDTH-1:0] DZ_QUOT  = WIDTH'($signed(DIV_DZ_QUOT));
   localparam logic [WIDTH-1:0] NEG_ONE  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] INT_MIN  = WIDTH'(DIV_INT_MIN[15]) << (WIDTH - 1);

   div_state_t       state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [WIDTH-1:0] quot_reg, rem_reg;
   logic             dz_reg, ovf_reg, tmo_reg;
   logic             start_reg, clk_en_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic is_dz, is_ovf, cnt_expired;

   assign is_dz       = (op_b == '0);
   assign is_ovf      = (op_a == INT_MIN) && (op_b == NEG_ONE);
   assign cnt_expired = (cnt_reg == CNT_LAST);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               // Screened operations skip the divider entirely.
               state_next = (is_dz || is_ovf) ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_next = ST_WAIT;
         ST_WAIT: begin
            // div_valid takes priority over an expiring counter in the same cycle.
            if (div_valid || cnt_expired) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         quot_reg   <= '0;
         rem_reg    <= '0;
         dz_reg     <= 1'b0;
         ovf_reg    <= 1'b0;
         tmo_reg    <= 1'b0;
         start_reg  <= 1'b0;
         clk_en_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         // Both strobes are decoded from the next state so they are glitch-free
         // flops aligned with LAUNCH (start) and LAUNCH..capture (clock enable).
         start_reg  <= (state_next == ST_LAUNCH);
         clk_en_reg <= (state_next == ST_LAUNCH) || (state_next == ST_WAIT);

         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  a_reg   <= op_a;
                  b_reg   <= op_b;
                  dz_reg  <= 1'b0;
                  ovf_reg <= 1'b0;
                  tmo_reg <= 1'b0;
                  if (is_dz) begin
                     quot_reg <= DZ_QUOT;
                     rem_reg  <= op_a;
                     dz_reg   <= 1'b1;
                  end else if (is_ovf) begin
                     quot_reg <= INT_MIN;
                     rem_reg  <= '0;
                     ovf_reg  <= 1'b1;
                  end
               end
            end
            ST_LAUNCH: begin
               cnt_reg <= '0;
            end
            ST_WAIT: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (div_valid) begin
                  quot_reg <= div_quot;
                  rem_reg  <= div_rem;
               end else if (cnt_expired) begin
                  quot_reg <= '0;
                  rem_reg  <= '0;
                  tmo_reg  <= 1'b1;
               end
            end
            default: ;  // DONE: hold everything until consumed
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign req_ready  = (state_reg == ST_IDLE);
   assign res_valid  = (state_reg == ST_DONE);
   assign busy       = (state_reg != ST_IDLE);
   assign div_start  = start_reg;
   assign div_clk_en = clk_en_reg;
   assign div_a      = a_reg;
   assign div_b      = b_reg;
   assign res_quot   = quot_reg;
   assign res_rem    = rem_reg;
   assign res_dz     = dz_reg;
   assign res_ovf    = ovf_reg;
   assign res_tmo    = tmo_reg;

endmodule
